board_ctl: RTL and testbench
============================

Name: board_ctl

Overview:
Playfield occupancy controller for the falling-block game. It owns a 10-column by 20-row occupancy grid and accepts lock requests from the piece-movement controller, given as pixel coordinates on the 35 px lattice. For each lock it converts the coordinates to a cell, sets that cell, then scans for full rows and clears them, shifting the rows above downward. It also answers collision queries from the movement controller and serves row reads to the draw pipeline.

Parameters:
X0, 201, pixel x of column 0
Y0, 10, pixel y of row 0
CELL, 35, cell pitch in pixels
COLS, 10, grid width (fixed; the grid is 10 bits per row)
ROWS, 20, grid height

Ports:
pclk  in  1  clock
rst  in  1  synchronous active-high reset
lock_req  in  1  level request to lock a cell; held until lock_ack
lock_xpos  in  12  pixel x of the cell to lock
lock_ypos  in  12  pixel y of the cell to lock
lock_ack  out  1  one-cycle pulse when lock processing is complete
lock_err  out  1  one-cycle pulse, coincident with lock_ack, when the lock was rejected
busy  out  1  high whenever the FSM is not in IDLE
q_col  in  4  collision query column
q_row  in  5  collision query row
q_occ  out  1  registered occupancy of (q_col, q_row)
rd_row  in  5  draw read row index
rd_bits  out  10  registered contents of row rd_row; bit c = column c
clear_pulse  out  1  one-cycle pulse per cleared row
lines  out  16  count of cleared rows, saturating at 0xFFFF
game_over  out  1  sticky flag

Behaviour:
- Reset (rst, synchronous, active-high; clock pclk):
  - grid all 0; state IDLE.
  - lock_ack, lock_err, clear_pulse, busy, q_occ, game_over all 0; rd_bits 0; lines 0.
  - rst mid-operation aborts the sequence immediately; no ack is issued.
- Grid storage: 20 registers of 10 bits.
- States: IDLE, CONV, WRITE, SCAN, SHIFT, DONE.
- IDLE, lock_req=1:
  - latch xr = lock_xpos - X0 and yr = lock_ypos - Y0 as 13-bit signed values.
  - clear the col and row counters; go to CONV.
  - lock_req is ignored in every other state.
- CONV: fixed 20 cycles, counted by an internal 5-bit counter.
  - Each cycle, if xr >= CELL: xr -= CELL, col += 1. Likewise for yr and row.
  - Exit to WRITE.
- WRITE (1 cycle): the lock is valid iff the latched differences were non-negative, xr == 0, yr == 0, col < 10 and row < 20.
  - Valid: set grid[row][col]. If row == 0, set game_over. Go to SCAN with scan index s = 19.
  - Invalid: grid unchanged; go to DONE with the error flagged.
- SCAN: one row per cycle, s counting 19 down to 0.
  - grid[s] == 10'h3FF: go to SHIFT.
  - Otherwise: if s == 0 go to DONE, else s -= 1.
- SHIFT (1 cycle):
  - for k = s down to 1, grid[k] <= grid[k-1]; grid[0] <= 0.
  - pulse clear_pulse; lines += 1 (saturating).
  - Return to SCAN with s unchanged, so the same row is rescanned.
- DONE (1 cycle):
  - lock_ack = 1; lock_err = 1 if invalid; return to IDLE.
  - The requester must drop lock_req in the cycle it sees lock_ack. If lock_req is still high when IDLE is re-entered, it starts a new lock.
- Latency: the accepting edge is cycle 0.
  - Valid lock, no clears: lock_ack in cycle 42.
  - Each cleared row adds 2 cycles.
  - Invalid lock: lock_ack in cycle 22.
- busy = (state != IDLE).
- Query port, 1-cycle latency, active in every state (reflects the grid as of the previous edge):
  - q_occ <= 1 if q_col >= 10 or q_row >= 20 (wall or floor);
  - otherwise q_occ <= grid[q_row][q_col].
- Read port, 1-cycle latency: rd_bits <= grid[rd_row] if rd_row < 20, else 10'h3FF.
- game_over: never cleared except by rst. Locks are still processed while it is set.
- Locking an already-occupied cell is not an error; the bit stays 1.

Test Plan:
- Reset, then lock (236, 675) → lock_ack in cycle 42, lock_err=0; query (1, 19) → q_occ=1 the next cycle; rd_row=19 → rd_bits=10'h002.
- Lock x = 201 + 35c for c = 0..9 at y = 675 → the tenth lock clears row 19: one clear_pulse, lines=1, ack in cycle 44, row 19 = 0.
- Preload rows 18 and 19 to 9 cells each (column 9 empty), set (516, 640) then (516, 675) → two clears across the sequence, lines=2; rows 0-19 = 0 except the shifted residue.
- Lock (237, 675) or (551, 10) → lock_ack with lock_err=1 in cycle 22; grid unchanged.
- Lock (236, 10) → game_over=1, stays high across later locks, cleared only by rst.
- Assert rst during SCAN → next cycle busy=0, grid=0, lines=0, no lock_ack; held lock_req restarts the sequence after rst falls.

Source files
------------

// File: rtl/board_ctl.sv
// -----------------------------------------------------------------------------
// board_ctl -- playfield occupancy controller for the falling-block game.
//
// Owns a 10-column x 20-row occupancy grid.  A lock request carries the pixel
// position of a cell on the 35 px lattice.  The controller converts it to a
// (col,row) cell by repeated subtraction, sets the cell, then scans the grid
// from the bottom row upward and clears every full row.  Clearing shifts the
// rows above it down by one.  Collision queries and draw-pipeline row reads
// are served every cycle, whatever the FSM is doing.
//
// Ports
//   pclk, rst              clock, synchronous active-high reset
//   lock_req               level request, held until lock_ack
//   lock_xpos, lock_ypos   pixel coordinates of the cell to lock
//   lock_ack               1-cycle pulse: lock processing finished
//   lock_err               1-cycle pulse with lock_ack: lock was rejected
//   busy                   FSM not idle
//   q_col, q_row, q_occ    collision query, registered result (walls/floor = 1)
//   rd_row, rd_bits        draw read, registered row contents (bit c = column c)
//   clear_pulse            1-cycle pulse per cleared row
//   lines                  saturating count of cleared rows
//   game_over              sticky, set by a lock into row 0
//
// Lock handshake: the requester raises lock_req with stable coordinates and
// keeps everything stable until it sees lock_ack; it must drop lock_req in the
// lock_ack cycle.  The controller only samples lock_req in IDLE, so a request
// still high when IDLE is re-entered is taken as a new lock.
// -----------------------------------------------------------------------------
module board_ctl #(
    parameter int X0   = 201,
    parameter int Y0   = 10,
    parameter int CELL = 35,
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        lock_req,
    input  logic [11:0] lock_xpos,
    input  logic [11:0] lock_ypos,
    output logic        lock_ack,
    output logic        lock_err,
    output logic        busy,
    input  logic [3:0]  q_col,
    input  logic [4:0]  q_row,
    output logic        q_occ,
    input  logic [4:0]  rd_row,
    output logic [9:0]  rd_bits,
    output logic        clear_pulse,
    output logic [15:0] lines,
    output logic        game_over
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CONV  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_SCAN  = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic signed [12:0] X0_S   = 13'(X0);
    localparam logic signed [12:0] Y0_S   = 13'(Y0);
    localparam logic signed [12:0] CELL_S = 13'(CELL);
    localparam logic [4:0]         CONV_LAST = 5'd19;
    localparam logic [4:0]         ROW_LAST  = 5'(ROWS - 1);

    logic [2:0]         state_q, state_d;
    logic signed [12:0] xr_q, xr_d;
    logic signed [12:0] yr_q, yr_d;
    logic [4:0]         col_q, col_d;
    logic [4:0]         row_q, row_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [4:0]         s_q, s_d;
    logic               bad_q, bad_d;
    logic [9:0]         grid_q [ROWS];
    logic [9:0]         grid_d [ROWS];
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic               clr_q, clr_d;
    logic [15:0]        lines_q, lines_d;
    logic               go_q, go_d;
    logic               q_occ_q, q_occ_d;
    logic [9:0]         rd_q, rd_d;

    logic               lock_valid;
    logic               row_full;

    // A negative difference keeps its sign through CONV (only values >= CELL
    // are reduced), so the sign bit still identifies an off-field coordinate.
    assign lock_valid = !xr_q[12] && !yr_q[12] &&
                        (xr_q == 13'sd0) && (yr_q == 13'sd0) &&
                        (col_q < 5'(COLS)) && (row_q < 5'(ROWS));

    always_comb begin
        row_full = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (s_q == 5'(r) && grid_q[r] == 10'h3FF) begin
                row_full = 1'b1;
            end
        end
    end

    // Main sequencing
    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        bad_d   = bad_q;
        grid_d  = grid_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        clr_d   = 1'b0;
        lines_d = lines_q;
        go_d    = go_q;

        case (state_q)
            S_IDLE: begin
                if (lock_req) begin
                    xr_d    = $signed({1'b0, lock_xpos}) - X0_S;
                    yr_d    = $signed({1'b0, lock_ypos}) - Y0_S;
                    col_d   = 5'd0;
                    row_d   = 5'd0;
                    cnt_d   = 5'd0;
                    bad_d   = 1'b0;
                    state_d = S_CONV;
                end
            end

            // Fixed-length division by repeated subtraction: 20 steps covers
            // the tallest axis; anything left over marks the lock invalid.
            S_CONV: begin
                if (xr_q >= CELL_S) begin
                    xr_d  = xr_q - CELL_S;
                    col_d = col_q + 5'd1;
                end
                if (yr_q >= CELL_S) begin
                    yr_d  = yr_q - CELL_S;
                    row_d = row_q + 5'd1;
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CONV_LAST) begin
                    state_d = S_WRITE;
                end
            end

            S_WRITE: begin
                if (lock_valid) begin
                    for (int r = 0; r < ROWS; r++) begin
                        for (int c = 0; c < COLS; c++) begin
                            if (row_q == 5'(r) && col_q == 5'(c)) begin
                                grid_d[r][c] = 1'b1;
                            end
                        end
                    end
                    if (row_q == 5'd0) begin
                        go_d = 1'b1;
                    end
                    s_d     = ROW_LAST;
                    state_d = S_SCAN;
                end else begin
                    bad_d   = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_SCAN: begin
                if (row_full) begin
                    state_d = S_SHIFT;
                end else if (s_q == 5'd0) begin
                    state_d = S_DONE;
                end else begin
                    s_d = s_q - 5'd1;
                end
            end

            // Drop row s; s is left unchanged so the row that slid into it is
            // examined on the next SCAN cycle.
            S_SHIFT: begin
                for (int k = 1; k < ROWS; k++) begin
                    if (5'(k) <= s_q) begin
                        grid_d[k] = grid_q[k-1];
                    end
                end
                grid_d[0] = '0;
                clr_d     = 1'b1;
                if (lines_q != 16'hFFFF) begin
                    lines_d = lines_q + 16'd1;
                end
                state_d = S_SCAN;
            end

            S_DONE: begin
                ack_d   = 1'b1;
                err_d   = bad_q;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Query and read ports: out-of-range coordinates read as solid.
    always_comb begin
        q_occ_d = 1'b1;
        if (q_col < 4'(COLS) && q_row < 5'(ROWS)) begin
            q_occ_d = 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (q_row == 5'(r) && q_col == 4'(c)) begin
                        q_occ_d = grid_q[r][c];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_d = 10'h3FF;
        for (int r = 0; r < ROWS; r++) begin
            if (rd_row == 5'(r)) begin
                rd_d = grid_q[r];
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= S_IDLE;
            xr_q    <= '0;
            yr_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            s_q     <= '0;
            bad_q   <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                grid_q[r] <= '0;
            end
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            clr_q   <= 1'b0;
            lines_q <= '0;
            go_q    <= 1'b0;
            q_occ_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            bad_q   <= bad_d;
            for (int r = 0; r < ROWS; r++) begin
                grid_q[r] <= grid_d[r];
            end
            ack_q   <= ack_d;
            err_q   <= err_d;
            clr_q   <= clr_d;
            lines_q <= lines_d;
            go_q    <= go_d;
            q_occ_q <= q_occ_d;
            rd_q    <= rd_d;
        end
    end

    assign lock_ack    = ack_q;
    assign lock_err    = err_q;
    assign busy        = (state_q != S_IDLE);
    assign q_occ       = q_occ_q;
    assign rd_bits     = rd_q;
    assign clear_pulse = clr_q;
    assign lines       = lines_q;
    assign game_over   = go_q;

endmodule

// File: tb/tb_board_ctl.sv
// -----------------------------------------------------------------------------
// tb_board_ctl -- self-checking bench for board_ctl.
//
// The reference model keeps the grid as 20 row words and handles a lock with
// plain arithmetic (divide / modulo on the pixel offsets) followed by a
// compaction that drops every full row.  Latency is predicted from the lock
// outcome: 22 cycles when rejected, 42 + 2 per cleared row otherwise.
// -----------------------------------------------------------------------------
module tb_board_ctl;

    logic        pclk = 1'b0;
    logic        rst;
    logic        lock_req;
    logic [11:0] lock_xpos;
    logic [11:0] lock_ypos;
    logic        lock_ack;
    logic        lock_err;
    logic        busy;
    logic [3:0]  q_col;
    logic [4:0]  q_row;
    logic        q_occ;
    logic [4:0]  rd_row;
    logic [9:0]  rd_bits;
    logic        clear_pulse;
    logic [15:0] lines;
    logic        game_over;

    int total = 0;
    int bad   = 0;

    logic [9:0] m_grid [20];
    int         m_lines;
    logic       m_go;
    logic [9:0] exp_q [$];

    board_ctl dut (
        .pclk        (pclk),
        .rst         (rst),
        .lock_req    (lock_req),
        .lock_xpos   (lock_xpos),
        .lock_ypos   (lock_ypos),
        .lock_ack    (lock_ack),
        .lock_err    (lock_err),
        .busy        (busy),
        .q_col       (q_col),
        .q_row       (q_row),
        .q_occ       (q_occ),
        .rd_row      (rd_row),
        .rd_bits     (rd_bits),
        .clear_pulse (clear_pulse),
        .lines       (lines),
        .game_over   (game_over)
    );

    // ---------------- clock / reset ----------------
    always #5 pclk = ~pclk;

    task automatic model_reset();
        for (int r = 0; r < 20; r++) m_grid[r] = '0;
        m_lines = 0;
        m_go    = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        lock_req = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- reference model ----------------
    task automatic model_lock(input int x, input int y, output bit ok, output int clears);
        int dx, dy;
        logic [9:0] kept [$];
        dx = x - 201;
        dy = y - 10;
        ok = (dx >= 0) && (dy >= 0) && (dx % 35 == 0) && (dy % 35 == 0) &&
             (dx / 35 < 10) && (dy / 35 < 20);
        clears = 0;
        if (ok) begin
            m_grid[dy / 35][dx / 35] = 1'b1;
            if (dy / 35 == 0) m_go = 1'b1;
            for (int r = 19; r >= 0; r--) begin
                if (m_grid[r] == 10'h3FF) clears++;
                else kept.push_back(m_grid[r]);
            end
            for (int r = 19; r >= 0; r--) begin
                if (kept.size() > 0) m_grid[r] = kept.pop_front();
                else m_grid[r] = '0;
            end
            m_lines = m_lines + clears;
            if (m_lines > 65535) m_lines = 65535;
        end
    endtask

    function automatic int exp_latency(input bit ok, input int clears);
        return ok ? 42 + 2 * clears : 22;
    endfunction

    // ---------------- drivers ----------------
    // Called #1 after a rising edge with the DUT idle.  The next edge accepts
    // the request (cycle 0); lat is the cycle in which lock_ack is seen.
    task automatic run_lock(input int x, input int y, output int lat, output bit err,
                            output int pulses, output bit busy_seen);
        lat       = -1;
        err       = 1'b0;
        pulses    = 0;
        lock_xpos = 12'(x);
        lock_ypos = 12'(y);
        lock_req  = 1'b1;
        @(posedge pclk);
        #1;
        busy_seen = busy;
        for (int n = 1; n <= 300; n++) begin
            @(posedge pclk);
            #1;
            if (clear_pulse) pulses++;
            if (lock_ack) begin
                lat      = n;
                err      = lock_err;
                lock_req = 1'b0;
                break;
            end
        end
        lock_req = 1'b0;
    endtask

    task automatic read_row(input int r, output logic [9:0] bits);
        rd_row = 5'(r);
        @(posedge pclk);
        #1;
        bits = rd_bits;
    endtask

    task automatic query(input int c, input int r, output logic occ);
        q_col = 4'(c);
        q_row = 5'(r);
        @(posedge pclk);
        #1;
        occ = q_occ;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (lock_ack !== 1'b0)    begin bad++; $display("FAIL reset_ack: got %b want 0", lock_ack); end
        total++; if (lock_err !== 1'b0)    begin bad++; $display("FAIL reset_err: got %b want 0", lock_err); end
        total++; if (clear_pulse !== 1'b0) begin bad++; $display("FAIL reset_clr: got %b want 0", clear_pulse); end
        total++; if (q_occ !== 1'b0)       begin bad++; $display("FAIL reset_qocc: got %b want 0", q_occ); end
        total++; if (rd_bits !== 10'h000)  begin bad++; $display("FAIL reset_rd: got %h want 000", rd_bits); end
        total++; if (lines !== 16'd0)      begin bad++; $display("FAIL reset_lines: got %0d want 0", lines); end
        total++; if (game_over !== 1'b0)   begin bad++; $display("FAIL reset_go: got %b want 0", game_over); end
    endtask

    task automatic test_single_lock();
        bit ok, err, bsy;
        int cl, lat, pulses;
        logic occ;
        logic [9:0] bits;
        do_reset();
        model_lock(236, 675, ok, cl);
        run_lock(236, 675, lat, err, pulses, bsy);
        total++; if (lat !== exp_latency(ok, cl)) begin bad++; $display("FAIL single_lat: got %0d want %0d", lat, exp_latency(ok, cl)); end
        total++; if (err !== 1'b0)  begin bad++; $display("FAIL single_err: got %b want 0", err); end
        total++; if (bsy !== 1'b1)  begin bad++; $display("FAIL single_busy: got %b want 1", bsy); end
        total++; if (pulses !== 0)  begin bad++; $display("FAIL single_pulses: got %0d want 0", pulses); end
        @(posedge pclk); #1;
        total++; if (lock_ack !== 1'b0) begin bad++; $display("FAIL single_ack_width: got %b want 0", lock_ack); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL single_idle: got %b want 0", busy); end
        query(1, 19, occ);
        total++; if (occ !== m_grid[19][1]) begin bad++; $display("FAIL q_hit: got %b want %b", occ, m_grid[19][1]); end
        query(0, 19, occ);
        total++; if (occ !== m_grid[19][0]) begin bad++; $display("FAIL q_miss: got %b want %b", occ, m_grid[19][0]); end
        query(10, 3, occ);
        total++; if (occ !== 1'b1) begin bad++; $display("FAIL q_wall: got %b want 1", occ); end
        query(2, 20, occ);
        total++; if (occ !== 1'b1) begin bad++; $display("FAIL q_floor: got %b want 1", occ); end
        read_row(19, bits);
        total++; if (bits !== 10'h002) begin bad++; $display("FAIL rd_row19: got %h want 002", bits); end
        read_row(25, bits);
        total++; if (bits !== 10'h3FF) begin bad++; $display("FAIL rd_oob: got %h want 3ff", bits); end
        total++; if (game_over !== 1'b0) begin bad++; $display("FAIL single_go: got %b want 0", game_over); end
    endtask

    task automatic test_row_clear();
        bit ok, err, bsy;
        int cl, lat, pulses;
        logic [9:0] bits;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            model_lock(201 + 35 * c, 675, ok, cl);
            run_lock(201 + 35 * c, 675, lat, err, pulses, bsy);
            total++; if (lat !== exp_latency(ok, cl)) begin bad++; $display("FAIL clr_lat c=%0d: got %0d want %0d", c, lat, exp_latency(ok, cl)); end
            total++; if (pulses !== cl) begin bad++; $display("FAIL clr_pulses c=%0d: got %0d want %0d", c, pulses, cl); end
        end
        total++; if (lat !== 44)     begin bad++; $display("FAIL clr_tenth_lat: got %0d want 44", lat); end
        total++; if (lines !== 16'd1) begin bad++; $display("FAIL clr_lines: got %0d want 1", lines); end
        read_row(19, bits);
        total++; if (bits !== 10'h000) begin bad++; $display("FAIL clr_row19: got %h want 000", bits); end
    endtask

    task automatic test_double_clear();
        bit ok, err, bsy;
        int cl, lat, pulses, sum_pulses;
        logic [9:0] bits;
        do_reset();
        sum_pulses = 0;
        for (int r = 18; r < 20; r++) begin
            for (int c = 0; c < 9; c++) begin
                model_lock(201 + 35 * c, 10 + 35 * r, ok, cl);
                run_lock(201 + 35 * c, 10 + 35 * r, lat, err, pulses, bsy);
                sum_pulses += pulses;
            end
        end
        model_lock(516, 640, ok, cl);
        run_lock(516, 640, lat, err, pulses, bsy);
        sum_pulses += pulses;
        total++; if (lat !== exp_latency(ok, cl)) begin bad++; $display("FAIL dbl_lat1: got %0d want %0d", lat, exp_latency(ok, cl)); end
        model_lock(516, 675, ok, cl);
        run_lock(516, 675, lat, err, pulses, bsy);
        sum_pulses += pulses;
        total++; if (lat !== exp_latency(ok, cl)) begin bad++; $display("FAIL dbl_lat2: got %0d want %0d", lat, exp_latency(ok, cl)); end
        total++; if (sum_pulses !== 2) begin bad++; $display("FAIL dbl_pulses: got %0d want 2", sum_pulses); end
        total++; if (lines !== 16'(m_lines)) begin bad++; $display("FAIL dbl_lines: got %0d want %0d", lines, m_lines); end
        for (int r = 0; r < 20; r++) begin
            read_row(r, bits);
            total++; if (bits !== m_grid[r]) begin bad++; $display("FAIL dbl_row%0d: got %h want %h", r, bits, m_grid[r]); end
        end
    endtask

    task automatic test_invalid();
        bit ok, err, bsy;
        int cl, lat, pulses;
        logic [9:0] bits;
        int xs [2] = '{237, 551};
        int ys [2] = '{675, 10};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            model_lock(xs[i], ys[i], ok, cl);
            run_lock(xs[i], ys[i], lat, err, pulses, bsy);
            total++; if (lat !== 22)   begin bad++; $display("FAIL inv_lat%0d: got %0d want 22", i, lat); end
            total++; if (err !== 1'b1) begin bad++; $display("FAIL inv_err%0d: got %b want 1", i, err); end
        end
        read_row(19, bits);
        total++; if (bits !== 10'h000) begin bad++; $display("FAIL inv_row19: got %h want 000", bits); end
        read_row(0, bits);
        total++; if (bits !== 10'h000) begin bad++; $display("FAIL inv_row0: got %h want 000", bits); end
        total++; if (game_over !== 1'b0) begin bad++; $display("FAIL inv_go: got %b want 0", game_over); end
    endtask

    task automatic test_game_over();
        bit ok, err, bsy;
        int cl, lat, pulses;
        do_reset();
        model_lock(236, 10, ok, cl);
        run_lock(236, 10, lat, err, pulses, bsy);
        total++; if (game_over !== 1'b1) begin bad++; $display("FAIL go_set: got %b want 1", game_over); end
        model_lock(271, 675, ok, cl);
        run_lock(271, 675, lat, err, pulses, bsy);
        total++; if (lat !== exp_latency(ok, cl)) begin bad++; $display("FAIL go_lat: got %0d want %0d", lat, exp_latency(ok, cl)); end
        total++; if (game_over !== 1'b1) begin bad++; $display("FAIL go_sticky: got %b want 1", game_over); end
        do_reset();
        total++; if (game_over !== 1'b0) begin bad++; $display("FAIL go_rst: got %b want 0", game_over); end
    endtask

    task automatic test_reset_mid();
        bit ok, err, bsy;
        int cl, lat, pulses;
        logic [9:0] bits;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            model_lock(201 + 35 * c, 675, ok, cl);
            run_lock(201 + 35 * c, 675, lat, err, pulses, bsy);
        end
        model_lock(341, 675, ok, cl);
        run_lock(341, 675, lat, err, pulses, bsy);
        rd_row    = 5'd19;
        lock_xpos = 12'd236;
        lock_ypos = 12'd675;
        lock_req  = 1'b1;
        @(posedge pclk);
        repeat (25) @(posedge pclk);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        @(posedge pclk);
        #1;
        rst = 1'b0;
        model_reset();
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        total++; if (lock_ack !== 1'b0) begin bad++; $display("FAIL mid_ack: got %b want 0", lock_ack); end
        total++; if (lines !== 16'd0)   begin bad++; $display("FAIL mid_lines: got %0d want 0", lines); end
        // Held request restarts: the next edge is cycle 0 of the new lock.
        model_lock(236, 675, ok, cl);
        lat = -1;
        @(posedge pclk);
        #1;
        total++; if (rd_bits !== 10'h000) begin bad++; $display("FAIL mid_row19: got %h want 000", rd_bits); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_restart: got %b want 1", busy); end
        for (int n = 1; n <= 300; n++) begin
            @(posedge pclk);
            #1;
            if (lock_ack) begin
                lat      = n;
                lock_req = 1'b0;
                break;
            end
        end
        lock_req = 1'b0;
        total++; if (lat !== exp_latency(ok, cl)) begin bad++; $display("FAIL mid_lat: got %0d want %0d", lat, exp_latency(ok, cl)); end
        for (int r = 0; r < 20; r++) begin
            read_row(r, bits);
            total++; if (bits !== m_grid[r]) begin bad++; $display("FAIL mid_grid%0d: got %h want %h", r, bits, m_grid[r]); end
        end
    endtask

    task automatic test_random();
        bit ok, err, bsy;
        int cl, lat, pulses, x, y, c, r, kind;
        logic [9:0] bits, e;
        logic occ;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            c    = $urandom_range(0, 9);
            r    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 19) : $urandom_range(17, 19);
            x    = 201 + 35 * c;
            y    = 10 + 35 * r;
            if (kind == 7) x = ($urandom_range(0, 1) == 0) ? x + $urandom_range(1, 34) : $urandom_range(0, 200);
            if (kind == 8) x = 201 + 35 * $urandom_range(10, 22);
            if (kind == 9) y = $urandom_range(0, 9);
            model_lock(x, y, ok, cl);
            run_lock(x, y, lat, err, pulses, bsy);
            total++; if (lat !== exp_latency(ok, cl)) begin bad++; $display("FAIL rnd_lat (%0d,%0d): got %0d want %0d", x, y, lat, exp_latency(ok, cl)); end
            total++; if (err !== !ok) begin bad++; $display("FAIL rnd_err (%0d,%0d): got %b want %b", x, y, err, !ok); end
            total++; if (pulses !== cl) begin bad++; $display("FAIL rnd_pulses (%0d,%0d): got %0d want %0d", x, y, pulses, cl); end
            total++; if (lines !== 16'(m_lines)) begin bad++; $display("FAIL rnd_lines: got %0d want %0d", lines, m_lines); end
            total++; if (game_over !== m_go) begin bad++; $display("FAIL rnd_go: got %b want %b", game_over, m_go); end
            c = $urandom_range(0, 11);
            r = $urandom_range(15, 21);
            query(c, r, occ);
            total++; if (occ !== ((c >= 10 || r >= 20) ? 1'b1 : m_grid[r][c])) begin
                bad++; $display("FAIL rnd_q (%0d,%0d): got %b", c, r, occ);
            end
            if (i % 5 == 4) begin
                for (int k = 0; k < 20; k++) exp_q.push_back(m_grid[k]);
                for (int k = 0; k < 20; k++) begin
                    read_row(k, bits);
                    e = exp_q.pop_front();
                    total++; if (bits !== e) begin bad++; $display("FAIL rnd_row%0d: got %h want %h", k, bits, e); end
                end
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        rst       = 1'b1;
        lock_req  = 1'b0;
        lock_xpos = '0;
        lock_ypos = '0;
        q_col     = '0;
        q_row     = '0;
        rd_row    = '0;
        test_reset();
        test_single_lock();
        test_row_clear();
        test_double_clear();
        test_invalid();
        test_game_over();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
